// File: rtl/up_down_counter_with_load.sv
// Up/down binary counter with synchronous parallel load.
// The count wraps modulo 2^WIDTH, and load takes priority over counting.
module up_down_counter_with_load #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             up_dnb,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_p0;
  logic [WIDTH-1:0] next_p0;

  // Unsigned add/subtract of one; overflow bits are dropped so both ends wrap.
  function automatic logic [WIDTH-1:0] step_wrap(input logic [WIDTH-1:0] v,
                                                 input logic             up);
    logic [WIDTH-1:0] one;
    one = {{(WIDTH-1){1'b0}}, 1'b1};
    return up ? (v + one) : (v - one);
  endfunction

  always_comb begin
    next_p0 = step_wrap(cnt_p0, up_dnb);
    if (load_en) next_p0 = load_data;
  end

  // Stage p0: the only state in the block; reset wins over load and count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_p0 <= '0;
    else       cnt_p0 <= next_p0;
  end

  assign cnt = cnt_p0;

endmodule

// File: tb/tb_up_down_counter_with_load.sv
// Directed bench for up_down_counter_with_load.
// A vector table covers the main function; hand-written sequences cover the reset corners.
module tb_up_down_counter_with_load;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_en;
  logic [WIDTH-1:0] load_data;
  logic             up_dnb;
  logic [WIDTH-1:0] cnt;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic             ld;
    logic [WIDTH-1:0] d;
    logic             up;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs[22];

  up_down_counter_with_load #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .load_data (load_data),
    .up_dnb    (up_dnb),
    .cnt       (cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (cnt !== exp) begin
      n_fails++;
      $display("FAIL %s: cnt=%h expected=%h at t=%0t", name, cnt, exp, $time);
    end
  endtask

  // Drive inputs, take one rising edge, then sample 1 time unit later.
  task automatic step(input logic ld, input logic [WIDTH-1:0] d, input logic up,
                      input logic [WIDTH-1:0] exp, input string name);
    load_en   = ld;
    load_data = d;
    up_dnb    = up;
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  function automatic vec_t mk(input logic ld, input logic [WIDTH-1:0] d,
                              input logic up, input logic [WIDTH-1:0] exp);
    vec_t v;
    v.ld = ld; v.d = d; v.up = up; v.exp = exp;
    return v;
  endfunction

  initial begin
    // Up wrap D -> E, F, 0, 1
    vecs[0]  = mk(1, 4'hD, 1, 4'hD);
    vecs[1]  = mk(0, 4'h0, 1, 4'hE);
    vecs[2]  = mk(0, 4'h0, 1, 4'hF);
    vecs[3]  = mk(0, 4'h0, 1, 4'h0);
    vecs[4]  = mk(0, 4'h0, 1, 4'h1);
    // Down wrap 2 -> 1, 0, F, E
    vecs[5]  = mk(1, 4'h2, 0, 4'h2);
    vecs[6]  = mk(0, 4'h0, 0, 4'h1);
    vecs[7]  = mk(0, 4'h0, 0, 4'h0);
    vecs[8]  = mk(0, 4'h0, 0, 4'hF);
    vecs[9]  = mk(0, 4'h0, 0, 4'hE);
    // Load pulse while counting up
    vecs[10] = mk(1, 4'h5, 1, 4'h5);
    vecs[11] = mk(1, 4'hA, 1, 4'hA);
    vecs[12] = mk(0, 4'h3, 1, 4'hB);
    vecs[13] = mk(0, 4'h3, 1, 4'hC);
    // Load pulse while counting down
    vecs[14] = mk(1, 4'h5, 0, 4'h5);
    vecs[15] = mk(1, 4'hA, 0, 4'hA);
    vecs[16] = mk(0, 4'hF, 0, 4'h9);
    vecs[17] = mk(0, 4'hF, 0, 4'h8);
    // Held load with changing data, then resume counting
    vecs[18] = mk(1, 4'h3, 1, 4'h3);
    vecs[19] = mk(1, 4'h4, 1, 4'h4);
    vecs[20] = mk(1, 4'h5, 1, 4'h5);
    vecs[21] = mk(0, 4'h0, 1, 4'h6);

    reset = 1'b1; load_en = 1'b0; load_data = '0; up_dnb = 1'b1;
    #2;
    check("reset_state", 4'h0);
    @(posedge clk); #1;
    check("reset_held_edge", 4'h0);
    reset = 1'b0;
    #1;
    check("release_no_edge", 4'h0);

    for (int i = 0; i < 22; i++)
      step(vecs[i].ld, vecs[i].d, vecs[i].up, vecs[i].exp, $sformatf("vec%0d", i));

    // Asynchronous reset mid-cycle from 7, then count 1, 2, 3 after release
    step(1, 4'h7, 1, 4'h7, "load7");
    load_en = 1'b0;
    #2 reset = 1'b1;
    #1 check("async_reset", 4'h0);
    #1 reset = 1'b0;
    #1 check("post_release_hold", 4'h0);
    step(0, 4'h0, 1, 4'h1, "after_rst_1");
    step(0, 4'h0, 1, 4'h2, "after_rst_2");
    step(0, 4'h0, 1, 4'h3, "after_rst_3");

    // Reset overrides a pending load; first edge after release loads 9
    reset = 1'b1;
    load_en = 1'b1; load_data = 4'h9;
    @(posedge clk); #1;
    check("reset_vs_load", 4'h0);
    @(posedge clk); #1;
    check("reset_vs_load2", 4'h0);
    reset = 1'b0;
    step(1, 4'h9, 0, 4'h9, "load_after_rst");
    step(0, 4'h9, 0, 4'h8, "down_after_load");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
